// File: rtl/ysyx_24080006_clint_slave.sv
// CLINT machine timer behind an AXI4 responder: free-running 64-bit mtime,
// mtimecmp and a registered timer interrupt. Read and write channels run independent FSMs.
module ysyx_24080006_clint_slave #(
    parameter int TICK_DIV = 1,
    parameter int ID_W     = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     araddr,
    input  logic [ID_W-1:0] arid,
    input  logic [7:0]      arlen,
    input  logic            arvalid,
    output logic            arready,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic [ID_W-1:0] rid,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [31:0]     awaddr,
    input  logic [ID_W-1:0] awid,
    input  logic [7:0]      awlen,
    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [1:0]      bresp,
    output logic [ID_W-1:0] bid,
    output logic            bvalid,
    input  logic            bready,
    output logic            timer_irq
);
    localparam logic [0:0] R_IDLE   = 1'b0;
    localparam logic [0:0] R_RESP   = 1'b1;
    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_GOT_AW = 2'd1;
    localparam logic [1:0] W_GOT_W  = 2'd2;
    localparam logic [1:0] W_RESP   = 2'd3;

    function automatic logic reg_hit(input logic [15:0] off);
        return (off == 16'h0) || (off == 16'h4) || (off == 16'h8) || (off == 16'hC);
    endfunction

    logic [7:0]      presc_q, presc_d;
    logic [63:0]     mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [31:0]     shadow_q, shadow_d;
    logic            irq_q;
    logic [0:0]      rstate_q, rstate_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [1:0]      wstate_q, wstate_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic [15:0]     awoff_q;
    logic [7:0]      awlen_q;
    logic [ID_W-1:0] awid_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic            wlast_q;

    logic            tick, ar_fire, aw_fire, w_fire, have_aw, have_w, commit;
    logic [15:0]     w_off;
    logic [7:0]      w_len;
    logic [ID_W-1:0] w_id;
    logic [31:0]     w_data, wmask;
    logic [3:0]      w_strb;
    logic            w_last;
    logic            unused_addr;

    assign unused_addr = ^{araddr[31:16], awaddr[31:16]};

    assign arready   = (rstate_q == R_IDLE);
    assign rvalid    = (rstate_q == R_RESP);
    assign rlast     = rvalid;
    assign rdata     = rdata_q;
    assign rresp     = rresp_q;
    assign rid       = rid_q;
    assign awready   = (wstate_q == W_IDLE) || (wstate_q == W_GOT_W);
    assign wready    = (wstate_q == W_IDLE) || (wstate_q == W_GOT_AW);
    assign bvalid    = (wstate_q == W_RESP);
    assign bresp     = bresp_q;
    assign bid       = bid_q;
    assign timer_irq = irq_q;

    assign tick    = (presc_q == 8'(TICK_DIV - 1));
    assign ar_fire = arvalid && arready;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign have_aw = aw_fire || (wstate_q == W_GOT_AW);
    assign have_w  = w_fire || (wstate_q == W_GOT_W);

    // A channel handshaking this cycle is used directly so the commit lands in the same cycle.
    assign w_off  = aw_fire ? awaddr[15:0] : awoff_q;
    assign w_len  = aw_fire ? awlen : awlen_q;
    assign w_id   = aw_fire ? awid : awid_q;
    assign w_data = w_fire ? wdata : wdata_q;
    assign w_strb = w_fire ? wstrb : wstrb_q;
    assign w_last = w_fire ? wlast : wlast_q;
    assign wmask  = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};

    always_comb begin
        wstate_d = wstate_q;
        bresp_d  = bresp_q;
        bid_d    = bid_q;
        commit   = 1'b0;
        if (have_aw && have_w) begin
            if (w_len != 8'd0) begin
                // Bursts are drained beat by beat in W_GOT_AW until wlast.
                if (w_last) begin
                    wstate_d = W_RESP;
                    bresp_d  = 2'b10;
                    bid_d    = w_id;
                end else begin
                    wstate_d = W_GOT_AW;
                end
            end else begin
                wstate_d = W_RESP;
                bid_d    = w_id;
                bresp_d  = reg_hit(w_off) ? 2'b00 : 2'b11;
                commit   = reg_hit(w_off) && (w_strb != 4'd0);
            end
        end else if (aw_fire) begin
            wstate_d = W_GOT_AW;
        end else if (w_fire) begin
            wstate_d = W_GOT_W;
        end else if ((wstate_q == W_RESP) && bready) begin
            wstate_d = W_IDLE;
        end
    end

    always_comb begin
        presc_d    = tick ? 8'd0 : presc_q + 8'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (commit) begin
            case (w_off)
                16'h0:   mtime_d = {mtime_q[63:32], (mtime_q[31:0] & ~wmask) | (w_data & wmask)};
                16'h4:   mtime_d = {(mtime_q[63:32] & ~wmask) | (w_data & wmask), mtime_q[31:0]};
                16'h8:   mtimecmp_d[31:0]  = (mtimecmp_q[31:0] & ~wmask) | (w_data & wmask);
                16'hC:   mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~wmask) | (w_data & wmask);
                default: ;
            endcase
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rid_d    = rid_q;
        shadow_d = shadow_q;
        if (ar_fire) begin
            rstate_d = R_RESP;
            rid_d    = arid;
            rdata_d  = 32'd0;
            if (arlen != 8'd0) begin
                rresp_d = 2'b10;
            end else if (!reg_hit(araddr[15:0])) begin
                rresp_d = 2'b11;
            end else begin
                rresp_d = 2'b00;
                case (araddr[15:0])
                    16'h0: begin
                        rdata_d  = mtime_q[31:0];
                        shadow_d = mtime_q[63:32];
                    end
                    16'h4:   rdata_d = shadow_q;
                    16'h8:   rdata_d = mtimecmp_q[31:0];
                    default: rdata_d = mtimecmp_q[63:32];
                endcase
            end
        end else if ((rstate_q == R_RESP) && rready) begin
            rstate_d = R_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q    <= 8'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            shadow_q   <= 32'd0;
            irq_q      <= 1'b0;
            rstate_q   <= R_IDLE;
            rdata_q    <= 32'd0;
            rresp_q    <= 2'b00;
            rid_q      <= '0;
            wstate_q   <= W_IDLE;
            bresp_q    <= 2'b00;
            bid_q      <= '0;
            awoff_q    <= 16'd0;
            awlen_q    <= 8'd0;
            awid_q     <= '0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            wlast_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q   <= shadow_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
            rstate_q   <= rstate_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rid_q      <= rid_d;
            wstate_q   <= wstate_d;
            bresp_q    <= bresp_d;
            bid_q      <= bid_d;
            if (aw_fire) begin
                awoff_q <= awaddr[15:0];
                awlen_q <= awlen;
                awid_q  <= awid;
            end
            if (w_fire) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
                wlast_q <= wlast;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_24080006_clint_slave.sv
// Randomized bench for the CLINT responder; mtime is modelled as an epoch value
// plus elapsed clock edges, mtimecmp and the hi shadow as plain variables.
module tb_ysyx_24080006_clint_slave;
    localparam int ID_W = 4;

    logic            clock = 1'b0, reset = 1'b0;
    logic [31:0]     araddr = '0, awaddr = '0, wdata = '0;
    logic [ID_W-1:0] arid = '0, awid = '0;
    logic [7:0]      arlen = '0, awlen = '0;
    logic            arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic [3:0]      wstrb = '0;
    logic            arready, rlast, rvalid, awready, wready, bvalid, timer_irq;
    logic [31:0]     rdata;
    logic [1:0]      rresp, bresp;
    logic [ID_W-1:0] rid, bid;

    ysyx_24080006_clint_slave #(.TICK_DIV(1), .ID_W(ID_W)) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready), .timer_irq(timer_irq)
    );

    always #5 clock = ~clock;

    int edge_n;
    always @(posedge clock or negedge reset) begin
        if (!reset) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    int              n_chk = 0, n_fail = 0;
    logic [63:0]     ep_val, m_cmp;
    int              ep_edge;
    logic [31:0]     m_shadow, exp_rdata;
    logic [1:0]      exp_rresp, exp_bresp;
    logic [ID_W-1:0] exp_rid, exp_bid;
    logic            rd_burst;
    logic [15:0]     offs [8] = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10, 16'h2, 16'h1008, 16'hFFFC};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mtime as seen by logic clocked at edge n (value held just before that edge)
    function automatic logic [63:0] mt_at(input int n);
        return ep_val + 64'(n - 1 - ep_edge);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        ep_val = 64'd0; ep_edge = 0; m_cmp = '1; m_shadow = 32'd0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [ID_W-1:0] id);
        logic [63:0] cur;
        araddr = a; arlen = len; arid = id; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        cur = mt_at(edge_n);
        exp_rid = id; exp_rdata = 32'd0; rd_burst = (len != 8'd0); exp_rresp = 2'b00;
        if (rd_burst) exp_rresp = 2'b10;
        else case (a[15:0])
            16'h0: begin exp_rdata = cur[31:0]; m_shadow = cur[63:32]; end
            16'h4: exp_rdata = m_shadow;
            16'h8: exp_rdata = m_cmp[31:0];
            16'hC: exp_rdata = m_cmp[63:32];
            default: exp_rresp = 2'b11;
        endcase
        chk("rvalid", 64'(rvalid), 64'(1));
        chk("arready_busy", 64'(arready), 64'(0));
        chk("rlast", 64'(rlast), 64'(1));
        chk("rid", 64'(rid), 64'(exp_rid));
        chk("rresp", 64'(rresp), 64'(exp_rresp));
        if (!rd_burst) chk("rdata", 64'(rdata), 64'(exp_rdata));
    endtask

    task automatic r_finish(input int hold);
        repeat (hold) begin
            tick();
            chk("r_hold_valid", 64'(rvalid), 64'(1));
            chk("r_hold_resp", 64'(rresp), 64'(exp_rresp));
            if (!rd_burst) chk("r_hold_data", 64'(rdata), 64'(exp_rdata));
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("rvalid_clr", 64'(rvalid), 64'(0));
        chk("arready_back", 64'(arready), 64'(1));
    endtask

    // order: 0 = AW with first W, 1 = W first then AW after gap, 2 = AW first then W after gap
    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [ID_W-1:0] id,
                            input logic [31:0] d, input logic [3:0] s, input int order, input int gap);
        int          ce;
        logic [63:0] cur;
        awaddr = a; awlen = len; awid = id; wdata = d; wstrb = s;
        if (order == 1) begin
            wvalid = 1'b1; wlast = 1'b1;
            tick();
            wvalid = 1'b0;
            chk("wready_busy", 64'(wready), 64'(0));
            repeat (gap) begin tick(); chk("b_early", 64'(bvalid), 64'(0)); end
            awvalid = 1'b1;
            tick();
            awvalid = 1'b0;
        end else begin
            if (order == 2) begin
                awvalid = 1'b1;
                tick();
                awvalid = 1'b0;
                chk("awready_busy", 64'(awready), 64'(0));
                repeat (gap) begin tick(); chk("b_early", 64'(bvalid), 64'(0)); end
            end else begin
                awvalid = 1'b1;
            end
            for (int b = 0; b <= int'(len); b++) begin
                wvalid = 1'b1; wlast = (b == int'(len));
                if (b > 0) wdata = $urandom();
                tick();
                awvalid = 1'b0;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        ce = edge_n;
        exp_bid = id;
        if (len != 8'd0) exp_bresp = 2'b10;
        else if (!(a[15:0] inside {16'h0, 16'h4, 16'h8, 16'hC})) exp_bresp = 2'b11;
        else begin
            exp_bresp = 2'b00;
            cur = mt_at(ce);
            if (s != 4'd0) case (a[15:0])
                16'h0: begin ep_val = {cur[63:32], merge(cur[31:0], d, s)}; ep_edge = ce; end
                16'h4: begin ep_val = {merge(cur[63:32], d, s), cur[31:0]}; ep_edge = ce; end
                16'h8: m_cmp[31:0] = merge(m_cmp[31:0], d, s);
                default: m_cmp[63:32] = merge(m_cmp[63:32], d, s);
            endcase
        end
        chk("bvalid", 64'(bvalid), 64'(1));
        chk("bresp", 64'(bresp), 64'(exp_bresp));
        chk("bid", 64'(bid), 64'(exp_bid));
        chk("awready_resp", 64'(awready), 64'(0));
    endtask

    task automatic b_finish(input int hold);
        repeat (hold) begin
            tick();
            chk("b_hold_valid", 64'(bvalid), 64'(1));
            chk("b_hold_resp", 64'(bresp), 64'(exp_bresp));
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clr", 64'(bvalid), 64'(0));
        chk("awready_back", 64'(awready), 64'(1));
        chk("wready_back", 64'(wready), 64'(1));
    endtask

    function automatic logic exp_irq();
        return mt_at(edge_n) >= m_cmp;
    endfunction

    initial begin
        logic [63:0] tgt;
        model_reset();
        #2;
        chk("rst_arready", 64'(arready), 64'(1));
        chk("rst_awready", 64'(awready), 64'(1));
        chk("rst_wready", 64'(wready), 64'(1));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_bvalid", 64'(bvalid), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_rresp", 64'(rresp), 64'(0));
        chk("rst_bresp", 64'(bresp), 64'(0));
        chk("rst_rid", 64'(rid), 64'(0));
        chk("rst_bid", 64'(bid), 64'(0));
        chk("rst_rlast", 64'(rlast), 64'(0));
        chk("rst_irq", 64'(timer_irq), 64'(0));
        @(negedge clock); @(negedge clock);
        reset = 1'b1;

        // free-running count after reset
        repeat (10) tick();
        do_read(32'h0200_0000, 8'd0, 4'h5);
        chk("mtime_near10", 64'((rdata >= 32'd8) && (rdata <= 32'd12)), 64'(1));
        r_finish($urandom_range(0, 3));

        // lo wraps into hi; hi is read through the shadow
        do_write(32'h0200_0004, 8'd0, 4'h1, 32'h0, 4'hF, $urandom_range(0, 2), $urandom_range(0, 3));
        b_finish($urandom_range(0, 2));
        do_write(32'h0200_0000, 8'd0, 4'h2, 32'hFFFF_FFFF, 4'hF, $urandom_range(0, 2), $urandom_range(0, 3));
        b_finish($urandom_range(0, 2));
        repeat (2) tick();
        do_read(32'h0200_0000, 8'd0, 4'h3); r_finish(0);
        do_read(32'h0200_0004, 8'd0, 4'h4);
        chk("shadow_hi", 64'(rdata), 64'(1));
        r_finish(1);

        // interrupt rises at mtimecmp, drops when mtimecmp goes back to all-ones
        tgt = mt_at(edge_n) + 64'd40;
        do_write(32'h0200_000C, 8'd0, 4'h6, tgt[63:32], 4'hF, $urandom_range(0, 2), $urandom_range(0, 2));
        b_finish($urandom_range(0, 2));
        chk("irq_pre", 64'(timer_irq), 64'(exp_irq()));
        do_write(32'h0200_0008, 8'd0, 4'h7, tgt[31:0], 4'hF, $urandom_range(0, 2), $urandom_range(0, 2));
        b_finish($urandom_range(0, 2));
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("irq_track", 64'(timer_irq), 64'(exp_irq()));
        end
        chk("irq_up", 64'(timer_irq), 64'(1));
        do_write(32'h0200_000C, 8'd0, 4'h8, 32'hFFFF_FFFF, 4'hF, 0, 0);
        chk("irq_still", 64'(timer_irq), 64'(1));
        tick();
        chk("irq_drop", 64'(timer_irq), 64'(0));
        b_finish(0);
        do_write(32'h0200_0008, 8'd0, 4'h9, 32'hFFFF_FFFF, 4'hF, 0, 0);
        b_finish(0);

        // W well ahead of AW, two low byte lanes only
        do_write(32'h0200_0008, 8'd0, 4'hA, 32'hAAAA_BBBB, 4'b0011, 1, 2);
        b_finish(0);
        do_read(32'h0200_0008, 8'd0, 4'hB);
        chk("cmp_partial", 64'(rdata), 64'h0000_0000_FFFF_BBBB);
        r_finish(0);

        // decode error and write burst
        do_read(32'h0200_0010, 8'd0, 4'hC);
        chk("decerr", 64'(rresp), 64'(2'b11));
        r_finish(0);
        do_write(32'h0200_0008, 8'd3, 4'hD, 32'h1234_5678, 4'hF, 0, 0);
        chk("slverr", 64'(bresp), 64'(2'b10));
        b_finish(1);
        do_read(32'h0200_0008, 8'd0, 4'hE); r_finish(0);

        // both responses stalled, then reset mid-hold
        do_read(32'h0200_0008, 8'd0, 4'h1);
        do_write(32'h0200_000C, 8'd0, 4'h2, 32'h1234_5678, 4'hF, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_rdata", 64'(rdata), 64'(exp_rdata));
            chk("hold_bresp", 64'(bresp), 64'(exp_bresp));
            chk("hold_rvalid", 64'(rvalid), 64'(1));
            chk("hold_bvalid", 64'(bvalid), 64'(1));
            chk("hold_arready", 64'(arready), 64'(0));
            chk("hold_awready", 64'(awready), 64'(0));
        end
        #2 reset = 1'b0;
        #1;
        chk("arst_rvalid", 64'(rvalid), 64'(0));
        chk("arst_bvalid", 64'(bvalid), 64'(0));
        chk("arst_arready", 64'(arready), 64'(1));
        chk("arst_awready", 64'(awready), 64'(1));
        chk("arst_wready", 64'(wready), 64'(1));
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        // random traffic, including aliased upper address bits
        for (int it = 0; it < 40; it++) begin
            logic [31:0] a, r;
            int kind;
            r = $urandom();
            a = (r & 32'hFFFF_0000) | {16'h0, offs[$urandom_range(0, 7)]};
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                do_read(a, 8'd0, ID_W'($urandom()));
                r_finish($urandom_range(0, 3));
            end else if (kind < 8) begin
                do_write(a, 8'd0, ID_W'($urandom()), $urandom(), 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2), $urandom_range(0, 3));
                b_finish($urandom_range(0, 3));
            end else if (kind == 8) begin
                do_read(a, 8'($urandom_range(1, 7)), ID_W'($urandom()));
                r_finish($urandom_range(0, 2));
            end else begin
                do_write(a, 8'($urandom_range(1, 3)), ID_W'($urandom()), $urandom(), 4'hF,
                         2 * $urandom_range(0, 1), $urandom_range(0, 2));
                b_finish($urandom_range(0, 2));
            end
            chk("irq_rand", 64'(timer_irq), 64'(exp_irq()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_24080006_clint_slave.md
Name: ysyx_24080006_clint_slave

Overview:
AXI4 responder (slave end) for the core's LSU master port. It implements the CLINT machine timer: a free-running 64-bit mtime, a 64-bit mtimecmp, and a timer interrupt output. It sits behind the crossbar at base 0x0200_0000 and decodes only the low 16 bits of each address. The read and write channels have independent state machines.

Parameters:
TICK_DIV, 1, mtime increments once every TICK_DIV clocks; legal range 1..255.
ID_W, 4, AXI ID width.

Ports:
clock  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-low reset (0 = reset).
araddr  input  32  read address.
arid  input  ID_W  read ID.
arlen  input  8  burst length - 1.
arvalid  input  1  read address valid.
arready  output  1  read address ready.
rdata  output  32  read data.
rresp  output  2  read response.
rid  output  ID_W  echoed arid.
rlast  output  1  last beat; always 1 when rvalid is 1.
rvalid  output  1  read data valid.
rready  input  1  read data ready.
awaddr  input  32  write address.
awid  input  ID_W  write ID.
awlen  input  8  burst length - 1.
awvalid  input  1  write address valid.
awready  output  1  write address ready.
wdata  input  32  write data.
wstrb  input  4  byte strobes.
wlast  input  1  last write beat.
wvalid  input  1  write data valid.
wready  output  1  write data ready.
bresp  output  2  write response.
bid  output  ID_W  echoed awid.
bvalid  output  1  write response valid.
bready  input  1  write response ready.
timer_irq  output  1  registered (mtime >= mtimecmp), unsigned compare.

Behaviour:
Reset values (reset = 0):
- mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; prescaler count = 0; hi shadow = 0.
- arready = 1, awready = 1, wready = 1.
- rvalid = 0, bvalid = 0, rdata = 0, rresp = 0, bresp = 0, rid = 0, bid = 0, rlast = 0, timer_irq = 0.

Register map (offset = addr[15:0]):
- 0x0: mtime[31:0].
- 0x4: mtime[63:32].
- 0x8: mtimecmp[31:0].
- 0xC: mtimecmp[63:32].
- Any other offset, or addr[1:0] != 0: DECERR (2'b11). Reads return rdata = 0; writes are ignored.
- arlen != 0 or awlen != 0: SLVERR (2'b10), no register access, single response beat. For a write burst, every W beat up to wlast is consumed before B is issued.

Timer:
- The prescaler counts 0..TICK_DIV-1; mtime += 1 in the cycle the count wraps, with 64-bit wrap-around.
- A bus write to mtime in the same cycle as a tick: the write wins and the increment is dropped.
- A read of 0x0 latches mtime[63:32] into the hi shadow. A read of 0x4 returns the shadow, not the live value, so the lo-then-hi read pair is atomic.
- timer_irq updates one cycle after mtime or mtimecmp changes.

Read FSM (R_IDLE -> R_RESP):
- R_IDLE: arready = 1. On arvalid&arready, capture araddr/arid, compute rdata/rresp, assert rvalid next cycle, drop arready, go to R_RESP. Latency is exactly 1 cycle from the AR handshake to rvalid.
- R_RESP: hold rdata/rresp/rid stable until rvalid&rready, then go to R_IDLE with arready = 1 the following cycle. At most one read is outstanding.

Write FSM (W_IDLE, W_GOT_AW, W_GOT_W, W_RESP):
- AW and W are accepted in either order or in the same cycle; each ready drops after its own handshake.
- When both are held, the write commits with byte-lane granularity per wstrb, and bvalid asserts the next cycle.
- W_RESP: hold until bvalid&bready, then go to W_IDLE with both readies re-asserted.
- wstrb = 0 commits nothing and still returns OKAY.

Concurrency:
- A read and a write to the same register in the same cycle: the read returns the pre-write value.

Reset mid-transaction:
- Asynchronous reset clears both FSMs immediately; any pending response is dropped.

Test Plan:
- Reset released, TICK_DIV=1: after 10 clocks, read 0x0 -> rdata ≈ 10 (±2 for pipeline), rresp=0, rlast=1, rid echoed.
- Write mtime hi=0x0, lo=0xFFFF_FFFF; wait 2 ticks; read lo then hi -> hi shadow = 1, and the value pair is consistent.
- Write mtimecmp = mtime+5 (hi first, then lo) -> timer_irq rises within 5 ticks + 1 cycle; writing mtimecmp = all-ones drops it the next cycle.
- W beat presented 3 cycles before AW, wstrb=4'b0011 to 0x8 with wdata=0xAAAA_BBBB -> only mtimecmp[15:0] becomes 0xBBBB; bvalid 1 cycle after AW, bresp=0.
- Read 0x10 -> rresp=2'b11, rdata=0. Write with awlen=3 and 4 W beats -> single B with bresp=2'b10, no register changed.
- Hold rready=0 and bready=0 for 5 cycles -> rdata/bresp stable, arready/awready stay 0. Assert reset mid-hold -> rvalid/bvalid clear and arready/awready return to 1 immediately.
